// File: rtl/blink_edge_counter_if.sv
// rtl/blink_edge_counter_if.sv - signal bundle between the blinker consumer and its driver/display
//
// Purpose: groups the edge counter's control inputs and display outputs.
// Ports (as interface signals):
//   toggle_in  - asynchronous blinker square wave
//   hold       - discard detected edges while high
//   clear      - zero the count
//   bcd_lo/hi  - ones/tens BCD digits
//   seg_lo/hi  - active-high 7-segment patterns (bit0=a .. bit6=g)
//   edge_seen  - one-cycle pulse per detected rising edge
//   wrap       - one-cycle pulse when the count wraps to 00
// Modports: master drives the controls, slave is the counter itself.
interface blink_edge_counter_if;
  logic       toggle_in;
  logic       hold;
  logic       clear;
  logic [3:0] bcd_lo;
  logic [3:0] bcd_hi;
  logic [6:0] seg_lo;
  logic [6:0] seg_hi;
  logic       edge_seen;
  logic       wrap;

  modport master (
    output toggle_in, hold, clear,
    input  bcd_lo, bcd_hi, seg_lo, seg_hi, edge_seen, wrap
  );

  modport slave (
    input  toggle_in, hold, clear,
    output bcd_lo, bcd_hi, seg_lo, seg_hi, edge_seen, wrap
  );
endinterface

// File: rtl/blink_edge_counter.sv
// rtl/blink_edge_counter.sv - synchronized rising-edge counter with two-digit BCD and 7-segment output
//
// Purpose: synchronizes the blinker toggle, detects rising edges and counts
// them in a two-digit BCD counter that wraps to 00 after WRAP_AT.
// Parameters:
//   SYNC_STAGES - synchronizer depth, 2..4
//   WRAP_AT     - last count before wrapping to 00, 1..99
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - slave side of blink_edge_counter_if (controls in, digits/segments/pulses out)
module blink_edge_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_AT     = 99
) (
  input  logic                  clk,
  input  logic                  rst,
  blink_edge_counter_if.slave   bus
);

  generate
    if (WRAP_AT < 1 || WRAP_AT > 99) begin : g_bad_wrap
      $error("blink_edge_counter: WRAP_AT must be in 1..99");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("blink_edge_counter: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  localparam logic [3:0] WRAP_HI = 4'(WRAP_AT / 10);
  localparam logic [3:0] WRAP_LO = 4'(WRAP_AT % 10);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_cond;

  logic [3:0] lo_q, hi_q, lo_d, hi_d;
  logic       wrap_q, wrap_d;
  logic       edge_q;

  // Synchronizer and prev flop reset to 1 so an input that is already high
  // when reset lifts never looks like a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.toggle_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_cond = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Clear beats everything; a held edge is dropped, not queued.
  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    wrap_d = 1'b0;
    if (bus.clear) begin
      lo_d = 4'd0;
      hi_d = 4'd0;
    end else if (edge_cond && !bus.hold) begin
      if (hi_q == WRAP_HI && lo_q == WRAP_LO) begin
        lo_d   = 4'd0;
        hi_d   = 4'd0;
        wrap_d = 1'b1;
      end else if (lo_q == 4'd9) begin
        lo_d = 4'd0;
        hi_d = hi_q + 4'd1;
      end else begin
        lo_d = lo_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q   <= 4'd0;
      hi_q   <= 4'd0;
      wrap_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      wrap_q <= wrap_d;
      edge_q <= edge_cond;
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign bus.bcd_lo    = lo_q;
  assign bus.bcd_hi    = hi_q;
  assign bus.seg_lo    = seg_decode(lo_q);
  assign bus.seg_hi    = seg_decode(hi_q);
  assign bus.edge_seen = edge_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_blink_edge_counter.sv
// tb/tb_blink_edge_counter.sv - directed self-checking bench for blink_edge_counter
module tb_blink_edge_counter;

  logic clk;
  logic rst;

  blink_edge_counter_if bus ();
  blink_edge_counter_if bus5 ();

  blink_edge_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  blink_edge_counter #(.SYNC_STAGES(2), .WRAP_AT(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int edge_cnt;
  int wrap_cyc;
  int wrap5_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; returns 1 time unit after the rising edge and tallies pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.edge_seen === 1'b1) edge_cnt++;
    if (bus.wrap === 1'b1) wrap_cyc++;
    if (bus5.wrap === 1'b1) wrap5_cyc++;
  endtask

  task automatic set_toggle(input logic v);
    bus.toggle_in  = v;
    bus5.toggle_in = v;
  endtask

  task automatic pulse(input int hi_cycles, input int lo_cycles);
    set_toggle(1'b1);
    repeat (hi_cycles) tick();
    set_toggle(1'b0);
    repeat (lo_cycles) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_toggle(1'b0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    edge_cnt  = 0;
    wrap_cyc  = 0;
    wrap5_cyc = 0;
  endtask

  function automatic logic [31:0] cnt(input logic [3:0] h, input logic [3:0] l);
    return {24'd0, h, l};
  endfunction

  int exp5 [7];

  initial begin
    n_vec = 0; n_bad = 0; edge_cnt = 0; wrap_cyc = 0; wrap5_cyc = 0;
    bus.hold = 1'b0;  bus.clear = 1'b0;
    bus5.hold = 1'b0; bus5.clear = 1'b0;
    set_toggle(1'b1);

    // Reset with toggle held high, then release: no edge, count 00.
    rst = 1'b1;
    repeat (10) tick();
    check("rst_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h00);
    check("rst_seg_lo", bus.seg_lo, 32'h3F);
    check("rst_seg_hi", bus.seg_hi, 32'h3F);
    rst = 1'b0;
    edge_cnt = 0;
    repeat (10) tick();
    check("rel_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h00);
    check("rel_seg", {bus.seg_hi, bus.seg_lo}, {18'd0, 7'h3F, 7'h3F});
    check("rel_edges", edge_cnt, 0);
    set_toggle(1'b0);
    repeat (4) tick();

    // 12 clean pulses; the first one is checked for 2-clock latency.
    do_reset();
    set_toggle(1'b1);
    tick();                                   // sampling edge N
    check("lat_n", bus.edge_seen, 0);
    tick();                                   // N+1
    check("lat_n1", bus.edge_seen, 0);
    tick();                                   // N+2
    check("lat_n2", bus.edge_seen, 1);
    check("lat_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h01);
    tick();
    check("lat_width", bus.edge_seen, 0);
    set_toggle(1'b0);
    repeat (4) tick();
    for (int i = 1; i < 12; i++) pulse(4, 4);
    check("p12_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h12);
    check("p12_seg_hi", bus.seg_hi, 32'h06);
    check("p12_seg_lo", bus.seg_lo, 32'h5B);
    check("p12_edges", edge_cnt, 12);

    // 100 pulses at WRAP_AT=99; also exercises 9->0 carries.
    do_reset();
    for (int i = 0; i < 99; i++) pulse(2, 2);
    check("p99_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h99);
    check("p99_seg", {bus.seg_hi, bus.seg_lo}, {18'd0, 7'h6F, 7'h6F});
    check("p99_wrap", wrap_cyc, 0);
    pulse(2, 2);
    check("p100_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h00);
    check("p100_wrap", wrap_cyc, 1);

    // WRAP_AT=5 instance: 1,2,3,4,5,0,1 with wrap only on the 6th pulse.
    do_reset();
    exp5 = '{1, 2, 3, 4, 5, 0, 1};
    for (int i = 0; i < 7; i++) begin
      pulse(3, 3);
      check($sformatf("w5_cnt%0d", i + 1), cnt(bus5.bcd_hi, bus5.bcd_lo), exp5[i]);
      check($sformatf("w5_wrap%0d", i + 1), wrap5_cyc, (i >= 5) ? 1 : 0);
    end

    // hold across pulses 3-4 of 6.
    do_reset();
    pulse(4, 4);
    pulse(4, 4);
    bus.hold = 1'b1;
    pulse(4, 4);
    pulse(4, 4);
    bus.hold = 1'b0;
    pulse(4, 4);
    pulse(4, 4);
    check("hold_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h04);
    check("hold_edges", edge_cnt, 6);

    // clear coincident with an edge at count 07.
    do_reset();
    for (int i = 0; i < 7; i++) pulse(4, 4);
    check("pre_clr_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h07);
    set_toggle(1'b1);
    tick();                                   // N
    tick();                                   // N+1: edge condition now active
    bus.clear = 1'b1;
    tick();                                   // N+2
    bus.clear = 1'b0;
    check("clr_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h00);
    check("clr_wrap", bus.wrap, 0);
    check("clr_edge_seen", bus.edge_seen, 1);
    set_toggle(1'b0);
    repeat (4) tick();
    check("clr_hold_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h00);

    // Async reset mid-count at 37, between clock edges, toggle high at release.
    do_reset();
    for (int i = 0; i < 37; i++) pulse(2, 2);
    check("pre_rst_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h37);
    set_toggle(1'b1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h00);
    check("arst_seg", {bus.seg_hi, bus.seg_lo}, {18'd0, 7'h3F, 7'h3F});
    check("arst_edge", bus.edge_seen, 0);
    repeat (3) tick();
    rst = 1'b0;
    edge_cnt = 0;
    repeat (4) tick();
    check("arst_rel_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h00);
    check("arst_rel_edges", edge_cnt, 0);
    set_toggle(1'b0);
    repeat (3) tick();
    pulse(3, 3);
    check("arst_next_cnt", cnt(bus.bcd_hi, bus.bcd_lo), 32'h01);
    check("arst_next_seg", bus.seg_lo, 32'h06);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/blink_edge_counter.md
# blink_edge_counter

Downstream consumer of the LED blinker's `toggle` output. Synchronizes the incoming square wave and detects its rising edges. Counts the edges in a two-digit BCD counter with programmable wrap. Drives the two digits onto active-high 7-segment outputs for the lab board's display.

## Interface
- `SYNC_STAGES`, default 2: depth of the input synchronizer chain; legal range 2..4.
- `WRAP_AT`, default 99: last count value before wrapping to 00; legal range 1..99, any other value is an elaboration error.
- `clk  input  1`: single system clock; all logic on its rising edge.
- `rst  input  1`: reset, asynchronous, active-high; clears all state immediately, no clock required.
- `toggle_in  input  1`: blinker output; treated as asynchronous.
- `hold  input  1`: synchronous; while high, detected edges are discarded.
- `clear  input  1`: synchronous; zeroes the count.
- `bcd_lo  output  4`: ones digit, BCD.
- `bcd_hi  output  4`: tens digit, BCD.
- `seg_lo  output  7`: 7-segment pattern for `bcd_lo`; bit0=a … bit6=g, active-high.
- `seg_hi  output  7`: 7-segment pattern for `bcd_hi`.
- `edge_seen  output  1`: one-cycle pulse per detected rising edge.
- `wrap  output  1`: one-cycle pulse when the count wraps from `WRAP_AT` to 00.

## Operation
- Synchronizer: `SYNC_STAGES` flops in series, followed by one `prev` flop holding the previous synchronized value.
- Reset value of all synchronizer flops and `prev` is 1. A blinker that comes out of reset high, or any input level present at reset, therefore produces no spurious edge.
- Edge condition: synchronized value is 1 and `prev` is 0. Falling edges are ignored.
- `edge_seen` (registered) follows the edge condition one clock later. It pulses regardless of `hold` or `clear`.
- Count update priority, evaluated each clock:
  1. `clear` = 1: count ← 00, `wrap` ← 0. A simultaneous edge is lost.
  2. Else edge condition with `hold` = 1: count unchanged. The edge is not queued.
  3. Else edge condition with count == `WRAP_AT`: count ← 00, `wrap` ← 1.
  4. Else edge condition: BCD increment. `bcd_lo` 9 → 0 with `bcd_hi` + 1; otherwise `bcd_lo` + 1.
  5. Otherwise: count holds, `wrap` ← 0.
- Comparison against `WRAP_AT` uses the BCD pair: tens = `WRAP_AT`/10, ones = `WRAP_AT`%10.
- Segment decode is combinational from the registered BCD digits:
  - 0 → 0x3F, 1 → 0x06, 2 → 0x5B, 3 → 0x4F, 4 → 0x66
  - 5 → 0x6D, 6 → 0x7D, 7 → 0x07, 8 → 0x7F, 9 → 0x6F
  - 10..15 (unreachable) → 0x00
- Reset values: `bcd_lo` = `bcd_hi` = 0, `seg_lo` = `seg_hi` = 0x3F, `edge_seen` = 0, `wrap` = 0.
- Reset asserted mid-operation:
  - all outputs take their reset values asynchronously;
  - synchronizer is refilled with 1s;
  - a `toggle_in` still high at release is not counted.

## Timing
- Latency: `toggle_in` first sampled high at clock edge N (low at N−1).
  - Last synchronizer stage is high after edge N+`SYNC_STAGES`−1.
  - Count, `edge_seen` and `wrap` update at edge N+`SYNC_STAGES`.
  - With default depth: sampled at N, visible after N+2.
- `edge_seen` and `wrap` are exactly one cycle wide.
- Minimum resolvable input: high ≥ 1 cycle and low ≥ 1 cycle, each stable across a sampling edge. Each such high phase yields exactly one count.
- `hold` and `clear` are sampled in the same cycle as the edge condition, i.e. the cycle before the count changes.
- Segment outputs change in the same cycle as the BCD outputs, with no added latency.

## Test plan
- Reset with `toggle_in` held high for 10 cycles, then release → count stays 00, `seg_lo` = `seg_hi` = 0x3F, no `edge_seen`.
- 12 clean pulses (4 cycles high, 4 low), default parameters → `bcd_hi`=1, `bcd_lo`=2; `seg_hi`=0x06, `seg_lo`=0x5B; `edge_seen` pulses 12 times, each 2 clocks after the sampling edge.
- `WRAP_AT`=99, 100 pulses → on the 100th pulse count returns to 00 and `wrap` pulses once, one cycle wide.
- `WRAP_AT`=5, 7 pulses → sequence 1,2,3,4,5,0,1; `wrap` fires on the 6th pulse only.
- `hold` high across pulses 3–4 of 6 → final count 04, `edge_seen` 6 pulses. `clear` coincident with an edge at count 07 → count 00, `wrap` 0.
- Async `rst` pulse mid-count (count 37, between clock edges) → outputs 00/0x3F immediately; next pulse after release → count 01.
